// File: rtl/bist_session_scheduler_if.sv
// CPU/BIST-side bundle of the session scheduler: command, results and per-core BIST hookup.
interface bist_session_scheduler_if #(
  parameter int unsigned NumCores = 4,
  parameter int unsigned SigWidth = 16,
  parameter int unsigned IdxWidth = 2
);
  logic                         start;
  logic                         abort;
  logic [NumCores-1:0]          core_mask;
  logic [NumCores*SigWidth-1:0] golden;
  logic [NumCores-1:0]          bist_done;
  logic [NumCores*SigWidth-1:0] signature;
  logic [NumCores-1:0]          bist_rst;
  logic                         busy;
  logic                         all_done;
  logic [IdxWidth-1:0]          cur_core;
  logic [NumCores-1:0]          pass_vec;
  logic [NumCores-1:0]          fail_vec;
  logic [NumCores-1:0]          timeout_vec;

  modport master (
    output start, abort, core_mask, golden, bist_done, signature,
    input  bist_rst, busy, all_done, cur_core, pass_vec, fail_vec, timeout_vec
  );

  modport slave (
    input  start, abort, core_mask, golden, bist_done, signature,
    output bist_rst, busy, all_done, cur_core, pass_vec, fail_vec, timeout_vec
  );
endinterface

// File: rtl/bist_session_scheduler.sv
// Runs the masked per-core BIST controllers one at a time (ascending index), with timeout,
// and records pass / fail / timeout per core against CPU-supplied golden signatures.
module bist_session_scheduler #(
  parameter int unsigned NumCores      = 4,
  parameter int unsigned SigWidth      = 16,
  parameter int unsigned TimeoutCycles = 4096,
  parameter int unsigned IdxWidth      = 2,
  parameter int unsigned TmrWidth      = 16
) (
  input  logic                      clk,
  input  logic                      rstIn,
  bist_session_scheduler_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    CHECK  = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t              state, stateNxt;
  logic [NumCores-1:0] pending, pendingNxt;
  logic [TmrWidth-1:0] timer, timerNxt;
  logic [IdxWidth-1:0] curCore, curCoreNxt;
  logic                busy, busyNxt;
  logic                allDone, allDoneNxt;
  logic [NumCores-1:0] passVec, passNxt;
  logic [NumCores-1:0] failVec, failNxt;
  logic [NumCores-1:0] toVec, toNxt;
  logic [NumCores-1:0] bistRst, bistRstNxt;
  logic [IdxWidth-1:0] lowIdx;
  logic                sigMatch;

  // Lowest set bit wins, giving ascending test order.
  function automatic logic [IdxWidth-1:0] lowestIdx(input logic [NumCores-1:0] m);
    lowestIdx = '0;
    for (int i = NumCores - 1; i >= 0; i--) begin
      if (m[i]) lowestIdx = IdxWidth'(i);
    end
  endfunction

  assign lowIdx   = lowestIdx(pending);
  assign sigMatch = (bus.signature[int'(curCore)*SigWidth +: SigWidth] ==
                     bus.golden[int'(curCore)*SigWidth +: SigWidth]);

  always_ff @(posedge clk) begin
    if (!rstIn) begin
      state   <= IDLE;
      pending <= '0;
      timer   <= '0;
      curCore <= '0;
      busy    <= 1'b0;
      allDone <= 1'b0;
      passVec <= '0;
      failVec <= '0;
      toVec   <= '0;
      bistRst <= '1;
    end else begin
      state   <= stateNxt;
      pending <= pendingNxt;
      timer   <= timerNxt;
      curCore <= curCoreNxt;
      busy    <= busyNxt;
      allDone <= allDoneNxt;
      passVec <= passNxt;
      failVec <= failNxt;
      toVec   <= toNxt;
      bistRst <= bistRstNxt;
    end
  end

  always_comb begin
    stateNxt   = state;
    pendingNxt = pending;
    timerNxt   = timer;
    curCoreNxt = curCore;
    busyNxt    = busy;
    allDoneNxt = allDone;
    passNxt    = passVec;
    failNxt    = failVec;
    toNxt      = toVec;
    bistRstNxt = '1;

    if (bus.abort && state != IDLE) begin
      // Abort beats every other transition; completed results survive.
      stateNxt   = IDLE;
      pendingNxt = '0;
      busyNxt    = 1'b0;
      allDoneNxt = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            pendingNxt = bus.core_mask;
            passNxt    = '0;
            failNxt    = '0;
            toNxt      = '0;
            allDoneNxt = 1'b0;
            busyNxt    = 1'b1;
            stateNxt   = SELECT;
          end
        end
        SELECT: begin
          if (pending == '0) begin
            stateNxt = FINISH;
          end else begin
            curCoreNxt         = lowIdx;
            pendingNxt[lowIdx] = 1'b0;
            stateNxt           = LAUNCH;
          end
        end
        LAUNCH: begin
          timerNxt = '0;
          stateNxt = WAIT;
        end
        WAIT: begin
          if (bus.bist_done[curCore]) begin
            stateNxt = CHECK;
          end else if (timer == TmrWidth'(TimeoutCycles - 1)) begin
            toNxt[curCore]   = 1'b1;
            failNxt[curCore] = 1'b1;
            stateNxt         = SELECT;
          end else begin
            timerNxt = timer + TmrWidth'(1);
          end
        end
        CHECK: begin
          if (sigMatch) passNxt[curCore] = 1'b1;
          else          failNxt[curCore] = 1'b1;
          stateNxt = SELECT;
        end
        FINISH: begin
          busyNxt    = 1'b0;
          allDoneNxt = 1'b1;
          stateNxt   = IDLE;
        end
        default: stateNxt = IDLE;
      endcase
    end

    // Only the core under test is released, and only while waiting or being checked.
    if (stateNxt == WAIT || stateNxt == CHECK) bistRstNxt[curCoreNxt] = 1'b0;
  end

  assign bus.bist_rst    = bistRst;
  assign bus.busy        = busy;
  assign bus.all_done    = allDone;
  assign bus.cur_core    = curCore;
  assign bus.pass_vec    = passVec;
  assign bus.fail_vec    = failVec;
  assign bus.timeout_vec = toVec;

endmodule
